// File: rtl/fact_pkg.sv
// Shared definitions for the factorial datapath and its control unit:
// operand/result widths and the 3-bit control-state codes.
package fact_pkg;

    localparam int SIZE  = 8;
    localparam int OUT_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        DEC   = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/fact_dp_if.sv
// Control-unit <-> factorial datapath bundle. The master (control unit) drives
// n/init/curr_state; the slave (fact_dp) returns proceed and the result.
interface fact_dp_if;
    import fact_pkg::*;

    // Handshake: init is a one-cycle load request honoured only in IDLE;
    // result is meaningful exactly while result_valid is high, and stays held
    // until the next accepted load (which drops result_valid on that edge).
    logic [SIZE-1:0]  n;
    logic             init;
    logic [2:0]       curr_state;
    logic             proceed;
    logic [OUT_W-1:0] result;
    logic             result_valid;
    logic             overflow;

    modport master (
        output n, init, curr_state,
        input  proceed, result, result_valid, overflow
    );

    modport slave (
        input  n, init, curr_state,
        output proceed, result, result_valid, overflow
    );

endinterface

// File: rtl/fact_mul.sv
// Combinational prod*cnt truncated to OUT_W bits. With FACT_DP_OVERFLOW_EN
// defined it also flags any nonzero bit of the full product above OUT_W-1.
module fact_mul
    import fact_pkg::*;
(
    input  logic [OUT_W-1:0] i_a,
    input  logic [SIZE-1:0]  i_b,
`ifdef FACT_DP_OVERFLOW_EN
    output logic             o_ovf,
`endif
    output logic [OUT_W-1:0] o_prod
);

`ifdef FACT_DP_OVERFLOW_EN
    logic [OUT_W+SIZE-1:0] w_full;

    assign w_full = (OUT_W+SIZE)'(i_a) * (OUT_W+SIZE)'(i_b);
    assign o_prod = w_full[OUT_W-1:0];
    assign o_ovf  = |w_full[OUT_W+SIZE-1:OUT_W];
`else
    // Only the low OUT_W bits are formed, so the product wraps modulo 2^OUT_W.
    assign o_prod = i_a * OUT_W'(i_b);
`endif

endmodule

// File: rtl/fact_dp.sv
// Factorial datapath steered by an external control unit through curr_state.
// Optional sticky overflow detection is enabled by FACT_DP_OVERFLOW_EN.
module fact_dp
    import fact_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    fact_dp_if.slave bus
);

    logic [SIZE-1:0]  r_cnt;
    logic [OUT_W-1:0] r_prod;
    logic [OUT_W-1:0] r_result;
    logic             r_result_valid;
    logic [OUT_W-1:0] w_mul_prod;
    logic             w_load;

`ifdef FACT_DP_OVERFLOW_EN
    logic r_ovf_acc;
    logic r_overflow;
    logic w_mul_ovf;
`endif

    assign w_load = bus.init && (bus.curr_state == IDLE);

    fact_mul u_mul (
        .i_a    (r_prod),
        .i_b    (r_cnt),
`ifdef FACT_DP_OVERFLOW_EN
        .o_ovf  (w_mul_ovf),
`endif
        .o_prod (w_mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_prod         <= OUT_W'(1);
            r_result       <= '0;
            r_result_valid <= 1'b0;
`ifdef FACT_DP_OVERFLOW_EN
            r_ovf_acc      <= 1'b0;
            r_overflow     <= 1'b0;
`endif
        end else begin
            case (bus.curr_state)
                IDLE: begin
                    if (w_load) begin
                        r_cnt          <= bus.n;
                        r_prod         <= OUT_W'(1);
                        r_result_valid <= 1'b0;
`ifdef FACT_DP_OVERFLOW_EN
                        r_ovf_acc      <= 1'b0;
`endif
                    end
                end
                MUL: begin
                    r_prod <= w_mul_prod;
`ifdef FACT_DP_OVERFLOW_EN
                    r_ovf_acc <= r_ovf_acc | w_mul_ovf;
`endif
                end
                DEC: begin
                    // Saturate so a stray DEC at zero cannot wrap and re-open the loop.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - SIZE'(1);
                    end
                end
                DONE: begin
                    r_result       <= r_prod;
                    r_result_valid <= 1'b1;
`ifdef FACT_DP_OVERFLOW_EN
                    r_overflow     <= r_ovf_acc;
`endif
                end
                default: begin
                    // CHECK and the undefined codes 5..7 hold every register.
                end
            endcase
        end
    end

    assign bus.proceed      = (r_cnt > SIZE'(1));
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
`ifdef FACT_DP_OVERFLOW_EN
    assign bus.overflow     = r_overflow;
`else
    assign bus.overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_fact_dp.sv
// Directed bench for fact_dp: a behavioural control unit walks CHECK/MUL/DEC/DONE
// from a table of operands, plus hand-written reset, stall and reload sequences.
module tb_fact_dp;
    import fact_pkg::*;

`ifdef FACT_DP_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0]  n;
        logic [31:0] exp_result;
        logic        exp_ovf;
        int          exp_lat;
        int          exp_muls;
        logic        exp_proceed;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fact_dp_if bus ();

    fact_dp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Control-unit model. Call while away from a clock edge with curr_state=IDLE.
    // stall_at >= 0 inserts three cycles of code 6 before that step of the loop.
    task automatic run_fact(input logic [7:0] nn, input bit poke_init, input int stall_at,
                            input bit chk_drop, input logic [31:0] held_res,
                            output logic [31:0] res, output logic ovf, output int lat,
                            output int muls, output logic first_proceed);
        logic [2:0] cs;
        logic [2:0] nxt;
        logic       p_before;
        bit         stalled;
        bus.n          = nn;
        bus.init       = 1'b1;
        bus.curr_state = IDLE;
        @(posedge clk);
        #1;
        bus.init       = 1'b0;
        bus.curr_state = CHECK;
        cs             = CHECK;
        lat            = 0;
        muls           = 0;
        stalled        = 1'b0;
        first_proceed  = bus.proceed;
        if (chk_drop) begin
            check("reload_valid_drop", {31'd0, bus.result_valid}, 32'd0);
            check("reload_result_held", bus.result, held_res);
        end
        while (!bus.result_valid && lat < 2000) begin
            if (stall_at == lat && !stalled) begin
                stalled        = 1'b1;
                p_before       = bus.proceed;
                bus.curr_state = 3'd6;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                check("stall_proceed_hold", {31'd0, bus.proceed}, {31'd0, p_before});
                check("stall_valid_hold", {31'd0, bus.result_valid}, 32'd0);
                bus.curr_state = cs;
            end
            case (cs)
                CHECK:   nxt = bus.proceed ? MUL : DONE;
                MUL: begin
                    muls++;
                    nxt = DEC;
                    if (poke_init && muls == 1) begin
                        bus.init = 1'b1;
                        bus.n    = 8'd2;
                    end
                end
                DEC:     nxt = CHECK;
                default: nxt = IDLE;
            endcase
            @(posedge clk);
            #1;
            bus.init       = 1'b0;
            lat++;
            cs             = nxt;
            bus.curr_state = nxt;
        end
        bus.curr_state = IDLE;
        res = bus.result;
        ovf = bus.overflow;
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] res;
        logic        ovf;
        logic        fp;
        int          lat;
        int          muls;

        vecs[0] = '{8'd0,   32'd1,          1'b0,   2,   0,   1'b0};
        vecs[1] = '{8'd1,   32'd1,          1'b0,   2,   0,   1'b0};
        vecs[2] = '{8'd2,   32'd2,          1'b0,   5,   1,   1'b1};
        vecs[3] = '{8'd3,   32'd6,          1'b0,   8,   2,   1'b1};
        vecs[4] = '{8'd5,   32'd120,        1'b0,   14,  4,   1'b1};
        vecs[5] = '{8'd12,  32'd479001600,  1'b0,   35,  11,  1'b1};
        vecs[6] = '{8'd13,  32'd1932053504, OVF_EN, 38,  12,  1'b1};
        vecs[7] = '{8'd255, 32'd0,          OVF_EN, 764, 254, 1'b1};

        rst_n          = 1'b0;
        bus.n          = '0;
        bus.init       = 1'b0;
        bus.curr_state = IDLE;
        #2;
        check("reset_result", bus.result, 32'd0);
        check("reset_valid", {31'd0, bus.result_valid}, 32'd0);
        check("reset_overflow", {31'd0, bus.overflow}, 32'd0);
        check("reset_proceed", {31'd0, bus.proceed}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(vecs[i].exp_result);
            run_fact(vecs[i].n, 1'b0, -1, 1'b0, 32'd0, res, ovf, lat, muls, fp);
            check($sformatf("n%0d_result", vecs[i].n), res, exp_q.pop_front());
            check($sformatf("n%0d_overflow", vecs[i].n), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
            check($sformatf("n%0d_latency", vecs[i].n), lat, vecs[i].exp_lat);
            check($sformatf("n%0d_mul_cycles", vecs[i].n), muls, vecs[i].exp_muls);
            check($sformatf("n%0d_first_proceed", vecs[i].n), {31'd0, fp}, {31'd0, vecs[i].exp_proceed});
        end

        // Stray DEC after n=0 must saturate the counter rather than wrap.
        run_fact(8'd0, 1'b0, -1, 1'b0, 32'd0, res, ovf, lat, muls, fp);
        bus.curr_state = DEC;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.curr_state = CHECK;
        #1;
        check("dec_saturate_proceed", {31'd0, bus.proceed}, 32'd0);
        check("dec_result_hold", bus.result, 32'd1);
        bus.curr_state = IDLE;
        @(posedge clk);
        #1;

        // Back-to-back: the second load drops result_valid but keeps result.
        run_fact(8'd3, 1'b0, -1, 1'b0, 32'd0, res, ovf, lat, muls, fp);
        check("b2b_first_result", res, 32'd6);
        run_fact(8'd4, 1'b0, -1, 1'b1, 32'd6, res, ovf, lat, muls, fp);
        check("b2b_second_result", res, 32'd24);

        // init raised during MUL is ignored.
        run_fact(8'd5, 1'b1, -1, 1'b0, 32'd0, res, ovf, lat, muls, fp);
        check("init_in_mul_result", res, 32'd120);
        check("init_in_mul_latency", lat, 14);

        // Undefined state code mid-run holds everything.
        run_fact(8'd6, 1'b0, 4, 1'b0, 32'd0, res, ovf, lat, muls, fp);
        check("stall_result", res, 32'd720);
        check("stall_latency", lat, 17);

        // Asynchronous reset in the middle of a MUL cycle of n=6.
        bus.n          = 8'd6;
        bus.init       = 1'b1;
        bus.curr_state = IDLE;
        @(posedge clk);
        #1;
        bus.init       = 1'b0;
        bus.curr_state = CHECK;
        @(posedge clk);
        #1;
        bus.curr_state = MUL;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_result", bus.result, 32'd0);
        check("async_rst_valid", {31'd0, bus.result_valid}, 32'd0);
        check("async_rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("async_rst_proceed", {31'd0, bus.proceed}, 32'd0);
        bus.curr_state = IDLE;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_fact(8'd4, 1'b0, -1, 1'b0, 32'd0, res, ovf, lat, muls, fp);
        check("post_rst_result", res, 32'd24);
        check("post_rst_overflow", {31'd0, ovf}, 32'd0);
        check("post_rst_latency", lat, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
